metaball_scheduler: RTL and testbench
=====================================

Name: metaball_scheduler

Overview:
- Frame-level sequencer for a bank of N_BALLS metaball units.
- Each frame tick, it advances every ball's position once. It then walks every pixel in raster order.
- Per pixel: broadcasts the sample coordinate, strobes all units, waits for every divider to complete, and sums the contributions with saturation.
- Thresholds the sum and writes one framebuffer word per pixel. Sits between the display timing logic and the metaball bank and framebuffer.

Parameters:
- N_BALLS, 4, number of metaball units driven (1..8)
- COLS, 32, display width in pixels
- ROWS, 64, display height in pixels
- THRESH, 32'h0000_8000, lit threshold on summed field, Q16.15 unsigned (1.0)
- AW, 11, framebuffer address width, ≥ clog2(COLS*ROWS)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse requesting a new frame (60 Hz)
- mov_en  out  1  one-cycle pulse to all units: advance position
- px_stb  out  1  one-cycle pulse to all units: start pixel calculation
- p_x  out  32  sample x, Q16.15 (x_cnt<<15)
- p_y  out  32  sample y, Q16.15 (y_cnt<<15)
- vld_in  in  N_BALLS  per-unit calculation-complete flags
- out_in  in  32*N_BALLS  per-unit contributions; unit i at [32i+31:32i]
- wr_en  out  1  framebuffer write strobe
- wr_addr  out  AW  y_cnt*COLS + x_cnt
- wr_data  out  1  1 = pixel lit (sum ≥ THRESH)
- wr_sum  out  32  saturated field sum for the written pixel
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse after the last pixel write
- overrun  out  1  one-cycle pulse when frame_tick arrives while busy

Behaviour:
- Reset values: all outputs 0, state IDLE, x_cnt = y_cnt = 0, sum = 0. Reset mid-frame aborts immediately; no further wr_en until the next frame_tick.
- FSM states: IDLE, MOVE, STROBE, GUARD, WAIT, SUM, WRITE, DONE.
- IDLE:
  - frame_tick → MOVE.
  - Other frame_tick pulses are ignored.
- MOVE: mov_en = 1 for exactly this cycle. x_cnt, y_cnt cleared. → STROBE.
- STROBE: px_stb = 1 for exactly this cycle. p_x/p_y already valid and held stable until the WRITE cycle ends. → GUARD.
- GUARD: one cycle; vld_in is ignored (the divider's complete flag may still be stale from the previous pixel). → WAIT.
- WAIT:
  - Stays until &vld_in == 1 → SUM.
  - No timeout.
  - Individual vld bits may rise on different cycles.
- SUM:
  - Registers sum = Σ out_in[i], computed at 33+ bits and saturated to 32'hFFFF_FFFF.
  - Contributions are treated as unsigned.
  - → WRITE.
- WRITE:
  - wr_en = 1 for exactly this cycle.
  - wr_addr = y_cnt*COLS + x_cnt, wr_data = (sum ≥ THRESH), wr_sum = sum.
  - Then x_cnt increments; at COLS-1 it wraps to 0 and y_cnt increments.
  - If x_cnt = COLS-1 and y_cnt = ROWS-1 → DONE, else → STROBE.
- DONE: frame_done = 1 for exactly this cycle. → IDLE.
- mov_en is never asserted while a pixel is in flight (STROBE through WRITE).
- frame_tick in any non-IDLE state pulses overrun on the same cycle. The frame in progress continues unaffected, and the tick is dropped (not queued).
- frame_tick and the DONE cycle coinciding counts as an overrun.
- wr_addr, wr_data and wr_sum hold their last values outside WRITE.
- Per-pixel latency = 4 + W cycles, where W ≥ 1 is the number of WAIT cycles.
- Frame length = 2 + COLS*ROWS*(4+W) cycles from frame_tick to the frame_done pulse.

Test Plan:
- Reset then frame_tick with COLS=4, ROWS=2, vld_in high 3 cycles after each px_stb:
  - → one mov_en;
  - 8 px_stb;
  - wr_addr 0..7 in order;
  - frame_done 2+8*(4+W) cycles after tick (W counted from GUARD exit);
  - busy low afterwards.
- Stale vld: vld_in held high through STROBE/GUARD, then dropped for 5 cycles, then raised → WAIT holds through the 5 low cycles; SUM occurs only after the re-rise.
- Sum/threshold with N_BALLS=2:
  - out_in = {0x4000, 0x3FFF} → wr_sum = 0x7FFF, wr_data = 0;
  - {0x4000, 0x4000} → 0x8000, wr_data = 1;
  - {0xFFFF_FFFF, 0x1} → wr_sum = 0xFFFF_FFFF, wr_data = 1.
- Staggered vld: unit 0 vld at +2, unit 1 vld at +9 → WAIT exits on the cycle after both are high; exactly one write per pixel.
- Overrun: frame_tick pulsed mid-frame and again on the DONE cycle → two overrun pulses, no extra mov_en, address sequence uninterrupted, IDLE after DONE.
- Reset mid-frame during WAIT at pixel 5 → all outputs 0 next cycle; subsequent frame_tick restarts at wr_addr 0 with one mov_en.

Source files
------------

// File: rtl/metaball_scheduler.sv
// Frame sequencer for a bank of metaball units: advances every ball once per frame, then
// walks the display in raster order, sums the per-unit contributions and writes one framebuffer word per pixel.
module metaball_scheduler #(
    parameter int          N_BALLS = 4,
    parameter int          COLS    = 32,
    parameter int          ROWS    = 64,
    parameter logic [31:0] THRESH  = 32'h0000_8000,
    parameter int          AW      = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_tick,
    output logic                   mov_en,
    output logic                   px_stb,
    output logic [31:0]            p_x,
    output logic [31:0]            p_y,
    input  logic [N_BALLS-1:0]     vld_in,
    input  logic [32*N_BALLS-1:0]  out_in,
    output logic                   wr_en,
    output logic [AW-1:0]          wr_addr,
    output logic                   wr_data,
    output logic [31:0]            wr_sum,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   overrun
);

    localparam int XW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int YW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int SW = N_BALLS + 32;

    localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_MOVE   = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_GUARD  = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_SUM    = 3'd5;
    localparam logic [2:0] S_WRITE  = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;
    logic [SW-1:0] acc;
    logic [31:0]   acc_sat;
    logic [AW-1:0] pix_addr;
    logic          last_pixel;

    assign last_pixel = (x_cnt == X_LAST) && (y_cnt == Y_LAST);
    assign pix_addr   = AW'(y_cnt) * AW'(COLS) + AW'(x_cnt);

    // GUARD exists because a divider's complete flag can still be high from the previous pixel.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (frame_tick) state_nxt = S_MOVE;
            S_MOVE:   state_nxt = S_STROBE;
            S_STROBE: state_nxt = S_GUARD;
            S_GUARD:  state_nxt = S_WAIT;
            S_WAIT:   if (&vld_in) state_nxt = S_SUM;
            S_SUM:    state_nxt = S_WRITE;
            S_WRITE:  state_nxt = last_pixel ? S_DONE : S_STROBE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Carry headroom of N_BALLS bits means the unsigned sum can never wrap before saturating.
    always_comb begin
        acc = '0;
        for (int i = 0; i < N_BALLS; i++) begin
            acc = acc + SW'(out_in[32*i +: 32]);
        end
        acc_sat = (|acc[SW-1:32]) ? 32'hFFFF_FFFF : acc[31:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            x_cnt   <= '0;
            y_cnt   <= '0;
            wr_sum  <= '0;
            wr_data <= 1'b0;
            wr_addr <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_MOVE: begin
                    x_cnt <= '0;
                    y_cnt <= '0;
                end
                S_SUM: begin
                    wr_sum  <= acc_sat;
                    wr_data <= (acc_sat >= THRESH);
                    wr_addr <= pix_addr;
                end
                S_WRITE: begin
                    if (x_cnt == X_LAST) begin
                        x_cnt <= '0;
                        y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + YW'(1);
                    end else begin
                        x_cnt <= x_cnt + XW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign mov_en     = (state == S_MOVE);
    assign px_stb     = (state == S_STROBE);
    assign wr_en      = (state == S_WRITE);
    assign frame_done = (state == S_DONE);
    assign busy       = (state != S_IDLE);
    assign overrun    = frame_tick && busy;
    assign p_x        = 32'(x_cnt) << 15;
    assign p_y        = 32'(y_cnt) << 15;

endmodule

// File: tb/tb_metaball_scheduler.sv
// Self-checking bench: a timeline model derives every cycle's expected outputs from the
// per-pixel vld delays the bench itself chooses, and a negedge process compares the DUT against it.
module tb_metaball_scheduler;

    localparam int          NB = 2;
    localparam int          C  = 4;
    localparam int          R  = 2;
    localparam int          P  = C * R;
    localparam int          AW = 3;
    localparam logic [31:0] TH = 32'h0000_8000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              frame_tick = 1'b0;
    logic              mov_en, px_stb, wr_en, wr_data, busy, frame_done, overrun;
    logic [31:0]       p_x, p_y, wr_sum;
    logic [NB-1:0]     vld_in = '0;
    logic [32*NB-1:0]  out_in = '0;
    logic [AW-1:0]     wr_addr;

    always #5 clk = ~clk;

    metaball_scheduler #(.N_BALLS(NB), .COLS(C), .ROWS(R), .THRESH(TH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .mov_en(mov_en), .px_stb(px_stb),
        .p_x(p_x), .p_y(p_y), .vld_in(vld_in), .out_in(out_in), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_sum(wr_sum), .busy(busy),
        .frame_done(frame_done), .overrun(overrun)
    );

    int          checks = 0;
    int          errors = 0;
    longint      cyc = 0;
    int          cur_mode = 0;
    bit          active = 0;
    longint      tick_c = 0;
    longint      done_c = 0;
    int          dly [P][NB];
    logic [31:0] dat [P][NB];
    bit          stale [P];
    longint      strobe_c [P];
    longint      write_c [P];
    int          mov_cnt = 0, stb_cnt = 0, ovr_cnt = 0;
    logic [AW-1:0] held_addr = '0;
    logic          held_data = 1'b0;
    logic [31:0]   held_sum = '0;

    function automatic logic [31:0] modelSum(int p);
        logic [63:0] s;
        s = '0;
        for (int i = 0; i < NB; i++) s = s + {32'd0, dat[p][i]};
        return (s > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    function automatic logic [31:0] randData();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 32'h8000));
            1:       return 32'($urandom_range(32'h3FF0, 32'h4010));
            2:       return $urandom;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Pixel p occupies STROBE, GUARD, W wait cycles, SUM and WRITE, with W = slowest unit delay + 1.
    task automatic planFrame(input longint t, input int mode);
        for (int p = 0; p < P; p++) begin
            stale[p] = 1'($urandom_range(0, 1));
            for (int i = 0; i < NB; i++) begin
                dly[p][i] = $urandom_range(0, 6);
                dat[p][i] = randData();
                case (mode)
                    1: dly[p][i] = 1;
                    3: dly[p][i] = 5;
                    4: dly[p][i] = (i == 0) ? 0 : 7;
                    5: dly[p][i] = 6;
                    default: ;
                endcase
            end
            if (mode == 3) stale[p] = 1'b1;
        end
        if (mode == 2) begin
            dat[0][1] = 32'h0000_4000; dat[0][0] = 32'h0000_3FFF;
            dat[1][1] = 32'h0000_4000; dat[1][0] = 32'h0000_4000;
            dat[2][1] = 32'hFFFF_FFFF; dat[2][0] = 32'h0000_0001;
        end
        for (int p = 0; p < P; p++) begin
            int w;
            w = 0;
            for (int i = 0; i < NB; i++) if (dly[p][i] > w) w = dly[p][i];
            w = w + 1;
            strobe_c[p] = (p == 0) ? t + 2 : write_c[p-1] + 1;
            write_c[p]  = strobe_c[p] + 3 + w;
        end
        done_c  = write_c[P-1] + 1;
        tick_c  = t;
        active  = 1'b1;
        mov_cnt = 0;
        stb_cnt = 0;
    endtask

    task automatic applyStimulus(input bit tick, input bit r);
        int pp;
        @(posedge clk);
        #1;
        cyc++;
        rst        = r;
        frame_tick = tick;
        if (r) active = 1'b0;
        else if (tick && (!active || cyc > done_c)) planFrame(cyc, cur_mode);
        pp = -1;
        for (int p = 0; p < P; p++)
            if (active && cyc >= strobe_c[p] && cyc <= write_c[p]) pp = p;
        if (pp < 0) begin
            vld_in = NB'($urandom);
            for (int i = 0; i < NB; i++) out_in[32*i +: 32] = $urandom;
        end else begin
            for (int i = 0; i < NB; i++) out_in[32*i +: 32] = dat[pp][i];
            if (cyc < strobe_c[pp] + 2) begin
                vld_in = stale[pp] ? '1 : NB'($urandom);
            end else begin
                for (int i = 0; i < NB; i++)
                    vld_in[i] = ((cyc - strobe_c[pp] - 2) >= longint'(dly[pp][i]));
            end
        end
    endtask

    // Per-cycle comparison of every DUT output against the timeline model.
    always @(negedge clk) begin
        if (rst) begin
            held_addr = '0;
            held_data = 1'b0;
            held_sum  = '0;
        end else if (cyc > 0) begin
            bit exp_mov, exp_stb, exp_wr, exp_done, exp_busy;
            int pp, wp;
            exp_mov  = active && (cyc == tick_c + 1);
            exp_done = active && (cyc == done_c);
            exp_busy = active && (cyc > tick_c) && (cyc <= done_c);
            exp_stb  = 1'b0;
            exp_wr   = 1'b0;
            pp = -1;
            wp = -1;
            for (int p = 0; p < P; p++) begin
                if (active && cyc >= strobe_c[p] && cyc <= write_c[p]) pp = p;
                if (active && cyc == strobe_c[p]) exp_stb = 1'b1;
                if (active && cyc == write_c[p]) begin exp_wr = 1'b1; wp = p; end
            end
            checkOutput("mov_en", 32'(mov_en), 32'(exp_mov));
            checkOutput("px_stb", 32'(px_stb), 32'(exp_stb));
            checkOutput("wr_en", 32'(wr_en), 32'(exp_wr));
            checkOutput("frame_done", 32'(frame_done), 32'(exp_done));
            checkOutput("busy", 32'(busy), 32'(exp_busy));
            checkOutput("overrun", 32'(overrun), 32'(frame_tick && exp_busy));
            if (pp >= 0) begin
                checkOutput("p_x", p_x, 32'((pp % C) << 15));
                checkOutput("p_y", p_y, 32'((pp / C) << 15));
            end
            if (wp >= 0) begin
                held_addr = AW'(wp);
                held_sum  = modelSum(wp);
                held_data = (held_sum >= TH);
                if (cur_mode == 2 && wp < 3) begin
                    checkOutput("lit_sum", wr_sum, (wp == 0) ? 32'h7FFF : (wp == 1) ? 32'h8000 : 32'hFFFF_FFFF);
                    checkOutput("lit_data", 32'(wr_data), (wp == 0) ? 32'd0 : 32'd1);
                end
            end
            checkOutput("wr_addr", 32'(wr_addr), 32'(held_addr));
            checkOutput("wr_data", 32'(wr_data), 32'(held_data));
            checkOutput("wr_sum", wr_sum, held_sum);
            if (mov_en) mov_cnt++;
            if (px_stb) stb_cnt++;
            if (overrun) ovr_cnt++;
            if (frame_done && cur_mode == 1) checkOutput("frame_len", 32'(cyc - tick_c), 32'd50);
            if (exp_done) begin
                checkOutput("mov_count", 32'(mov_cnt), 32'd1);
                checkOutput("stb_count", 32'(stb_cnt), 32'(P));
            end
        end
    end

    // ovr: 0 = no extra ticks, 1 = random ticks while busy, 2 = ticks mid-frame and on DONE.
    task automatic runFrame(input int mode, input int ovr);
        bit t;
        cur_mode = mode;
        ovr_cnt  = 0;
        applyStimulus(1'b1, 1'b0);
        for (int n = 0; n < 3000 && cyc <= done_c + 1; n++) begin
            t = 1'b0;
            if (ovr == 1) t = (cyc + 1 <= done_c) && ($urandom_range(0, 29) == 0);
            if (ovr == 2) t = (cyc + 1 == tick_c + 20) || (cyc + 1 == done_c);
            applyStimulus(t, 1'b0);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0);
        runFrame(1, 0);
        runFrame(2, 0);
        runFrame(3, 0);
        runFrame(4, 0);
        runFrame(0, 2);
        checkOutput("ovr_count", 32'(ovr_cnt), 32'd2);
        cur_mode = 5;
        applyStimulus(1'b1, 1'b0);
        for (int n = 0; n < 500 && cyc < strobe_c[5] + 3; n++) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);
        runFrame(1, 0);
        for (int f = 0; f < 6; f++) runFrame(0, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
